// File: rtl/fetch_pc_unit.sv
// IF-stage front end: owns the fetch PC, issues single-outstanding I-mem reads,
// follows BPU predictions and EX redirects, and queues fetched words for decode.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic [31:0] bpu_pc,
    input  logic [31:0] bpu_pc_predict,
    input  logic        bpu_br_taken,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target
);

    localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FQ_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SQUASH = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] target;
    } fq_entry_t;

    state_t            state;
    logic [31:0]       pc_q;
    logic [31:0]       req_pc;
    logic              req_taken;
    logic [31:0]       req_target;

    fq_entry_t         fq_mem [FQ_DEPTH];
    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [CNT_W-1:0]  count;

    logic              fq_full;
    logic              push;
    logic              pop;
    fq_entry_t         head_entry;
    fq_entry_t         push_entry;
    logic              unused_bits;

    assign fq_full    = (count == FULL_CNT);
    assign push       = (state == WAIT) && imem_resp && !ex_redirect;
    assign pop        = if_valid && if_ready && !ex_redirect;
    assign head_entry = fq_mem[head_ptr];
    assign push_entry = '{pc: req_pc, instr: imem_rdata, taken: req_taken, target: req_target};

    // Word alignment drops the low redirect bits.
    assign unused_bits = &{1'b0, ex_redirect_pc[1:0]};

    assign imem_read      = (state != IDLE);
    assign imem_addr      = req_pc;
    assign bpu_pc         = pc_q;
    assign if_valid       = (count != '0);
    assign if_pc          = head_entry.pc;
    assign if_instr       = head_entry.instr;
    assign if_pred_taken  = head_entry.taken;
    assign if_pred_target = head_entry.target;

    // Request FSM and fetch PC; a redirect overrides every PC update below it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc_q       <= RESET_PC;
            req_pc     <= RESET_PC;
            req_taken  <= 1'b0;
            req_target <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!ex_redirect && !fq_full) begin
                        req_pc     <= pc_q;
                        req_taken  <= bpu_br_taken;
                        req_target <= bpu_br_taken ? bpu_pc_predict : (pc_q + 32'd4);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (ex_redirect) begin
                        state <= imem_resp ? IDLE : SQUASH;
                    end else if (imem_resp) begin
                        pc_q  <= req_target;
                        state <= IDLE;
                    end
                end
                SQUASH: begin
                    if (imem_resp) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (ex_redirect) begin
                pc_q <= {ex_redirect_pc[31:2], 2'b00};
            end
        end
    end

    // Fetch queue; a flush discards everything including a coincident pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < int'(FQ_DEPTH); i++) begin
                fq_mem[i] <= '0;
            end
        end else if (ex_redirect) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fq_mem[tail_ptr] <= push_entry;
                tail_ptr         <= tail_ptr + PTR_W'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
